prog_loader: RTL and testbench
==============================

# prog_loader

Serial program loader that fills the CPU's 16-byte program RAM from a UART-style line. It drives the CPU's `prog`, `addr` and `programm_input` ports and holds the CPU in reset while a load is in progress. It sits directly upstream of the CPU. After the 16th byte is written it releases the CPU, which then starts executing from address 0.

## Interface
- `CLKS_PER_BIT`, default 16, clocks per serial bit; must be even and at least 4.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `rx`  input  1  serial line, idle high, 8N1, LSB first; asynchronous to `clk`.
- `load_start`  input  1  one-cycle request that arms a load session.
- `prog`  output  1  RAM write strobe to the CPU; one-cycle pulse per byte.
- `addr`  output  4  RAM write address to the CPU.
- `programm_input`  output  8  RAM write data to the CPU.
- `cpu_reset`  output  1  drives the CPU `reset`; high while loading.
- `busy`  output  1  load session active.
- `done`  output  1  one-cycle pulse when all 16 bytes are written.
- `frame_err`  output  1  sticky; set when a byte arrives with a bad stop bit.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- Internal state:
  - `byte_cnt[3:0]`: next RAM address.
  - `baud_cnt`: counts clocks within a bit.
  - `bit_cnt[2:0]`: data bit index.
  - `shift[7:0]`: received data, shifted in LSB first.
- FSM states: IDLE, ARM, START, DATA, STOP, WRITE, RELEASE.
- **IDLE**
  - `busy=0`, `cpu_reset=0`; `rx` is ignored.
  - `load_start=1` → ARM. On entry: `byte_cnt=0`, `frame_err` cleared, `cpu_reset=1`, `busy=1`.
- **ARM**
  - `rx_s==0` → START with `baud_cnt=0`.
- **START**
  - After `CLKS_PER_BIT/2` cycles (mid start bit), sample `rx_s`.
  - 0 → DATA with `baud_cnt=0`, `bit_cnt=0`.
  - 1 → ARM (glitch rejected).
- **DATA**
  - Every `CLKS_PER_BIT` cycles, shift `rx_s` into `shift[7]` (right shift).
  - After the 8th sample → STOP.
- **STOP**
  - After `CLKS_PER_BIT` cycles, sample `rx_s`.
  - 1 → WRITE.
  - 0 → set `frame_err`, discard the byte, leave `byte_cnt` unchanged, → ARM.
- **WRITE** (one cycle)
  - `prog=1`, `addr=byte_cnt`, `programm_input=shift`.
  - `byte_cnt==15` → RELEASE; otherwise increment `byte_cnt` and → ARM.
- **RELEASE** (one cycle)
  - `done=1`, `cpu_reset` falls at the end of this cycle, `busy` falls.
  - → IDLE.
- `load_start` is ignored in every state other than IDLE.
- `byte_cnt` never wraps within a session; exactly 16 writes occur per session.

## Timing
- All outputs are registered.
- Reset values:
  - `prog=0`, `addr=0`, `programm_input=0`, `busy=0`, `done=0`, `frame_err=0`.
  - `cpu_reset=1`; it falls on the first `clk` edge after `reset` deasserts, with the FSM in IDLE.
- `addr` and `programm_input` hold their value from WRITE until the next WRITE, so data is stable on the CPU's sampling edge when `prog=1`.
- Per byte, counted from the first cycle ARM sees `rx_s==0`: `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles, then a 1-cycle WRITE.
- Line-to-`rx_s` latency is 2 cycles.
- Back-to-back frames (stop bit immediately followed by a start bit) must not lose a byte. ARM is re-entered at the mid stop-bit sample, so the next falling edge is caught.
- `cpu_reset` stays high continuously from ARM entry through RELEASE. The CPU never runs on a partial program.
- `reset` asserted mid-session: all state and outputs return to reset values asynchronously. The partially written RAM is not cleared; a new `load_start` restarts at address 0.

## Structure
- The shared package holds:
  - the state enum (`LDR_IDLE` … `LDR_RELEASE`);
  - `PROG_ADDR_W=4`;
  - `PROG_DEPTH=16`;
  - the default `CLKS_PER_BIT`.
- One sub-module is natural: `prog_loader_rx`. It contains the synchronizer, START/DATA/STOP bit timing and the shifter, and outputs a `byte_valid` pulse, `byte_data` and a `stop_err` pulse.
- The top level keeps IDLE/ARM/WRITE/RELEASE, `byte_cnt` and the CPU-facing registers.

## Test plan
- **Full load:** `CLKS_PER_BIT=16`, `load_start`, 16 frames with data `0x60+i` → 16 `prog` pulses; `addr` runs 0..15 with matching data; `done` pulses once; `cpu_reset` falls the same cycle `busy` falls.
- **Frame error:** 4th frame has stop bit 0 → `frame_err=1`, no `prog` pulse; the next good frame `0xA5` is written to `addr=3`; the session still completes after 16 good bytes.
- **Glitch:** `rx` low for 3 clocks in ARM → no `prog` pulse, FSM returns to ARM; a following valid frame `0x3C` lands at `addr=0`.
- **Reset mid-load:** assert `reset` after 5 writes → `prog=0`, `busy=0`, `cpu_reset=1`; `cpu_reset` falls one clock after release; a new session writes its first byte to `addr=0`.
- **Ignored inputs:** `load_start` pulsed during a session and `rx` frames sent in IDLE → no effect on `byte_cnt`, no `prog` pulses.
- **Back-to-back frames:** 16 frames with zero idle time between them → all 16 bytes are written correctly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and sizing for the serial program loader.
package prog_loader_pkg;

    // Program RAM geometry seen by the CPU
    localparam int unsigned PROG_ADDR_W      = 4;
    localparam int unsigned PROG_DEPTH       = 16;
    localparam int unsigned PROG_DATA_W      = 8;

    // Default serial bit period in clocks (even, >= 4)
    localparam int unsigned LDR_CLKS_PER_BIT = 16;

    // Loader states; the receiver sub-module uses ARM/START/DATA/STOP,
    // the top level uses IDLE/ARM/WRITE/RELEASE.
    typedef enum logic [2:0] {
        LDR_IDLE    = 3'd0,
        LDR_ARM     = 3'd1,
        LDR_START   = 3'd2,
        LDR_DATA    = 3'd3,
        LDR_STOP    = 3'd4,
        LDR_WRITE   = 3'd5,
        LDR_RELEASE = 3'd6
    } ldr_state_t;

endpackage

// File: rtl/prog_loader_rx.sv
// 8N1 serial byte receiver: input synchronizer, bit timing and shifter.
// While disabled it parks in ARM waiting for a start bit.
module prog_loader_rx
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = LDR_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_en,
    input  logic                   i_rx,
    output logic                   o_byte_valid,
    output logic [PROG_DATA_W-1:0] o_byte_data,
    output logic                   o_stop_err
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);

    logic                   r_rx_meta;
    logic                   r_rx_s;
    ldr_state_t             r_state;
    logic [BAUD_W-1:0]      r_baud_cnt;
    logic [2:0]             r_bit_cnt;
    logic [PROG_DATA_W-1:0] r_shift;
    logic                   r_byte_valid;
    logic                   r_stop_err;

    // Two-flop synchronizer; idle level is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame timing: mid start-bit check, 8 data samples, mid stop-bit check
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= LDR_ARM;
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
            if (!i_en) begin
                r_state    <= LDR_ARM;
                r_baud_cnt <= '0;
            end else begin
                case (r_state)
                    LDR_ARM: begin
                        if (!r_rx_s) begin
                            r_state    <= LDR_START;
                            r_baud_cnt <= '0;
                        end
                    end
                    LDR_START: begin
                        if (r_baud_cnt == BAUD_HALF) begin
                            r_baud_cnt <= '0;
                            r_bit_cnt  <= '0;
                            // A high line at mid start bit is a glitch
                            r_state    <= r_rx_s ? LDR_ARM : LDR_DATA;
                        end else begin
                            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                        end
                    end
                    LDR_DATA: begin
                        if (r_baud_cnt == BAUD_FULL) begin
                            r_baud_cnt <= '0;
                            r_shift    <= {r_rx_s, r_shift[PROG_DATA_W-1:1]};
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= LDR_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end else begin
                            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                        end
                    end
                    LDR_STOP: begin
                        if (r_baud_cnt == BAUD_FULL) begin
                            // Re-arm at mid stop bit so a back-to-back start edge is caught
                            r_baud_cnt   <= '0;
                            r_state      <= LDR_ARM;
                            r_byte_valid <= r_rx_s;
                            r_stop_err   <= ~r_rx_s;
                        end else begin
                            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                        end
                    end
                    default: begin
                        r_state    <= LDR_ARM;
                        r_baud_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_shift;
    assign o_stop_err   = r_stop_err;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: fills the CPU's 16-byte program RAM from an 8N1
// line and holds the CPU in reset until the whole image is written.
// CLKS_PER_BIT must be even and at least 4.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = LDR_CLKS_PER_BIT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   load_start,
    output logic                   prog,
    output logic [PROG_ADDR_W-1:0] addr,
    output logic [PROG_DATA_W-1:0] programm_input,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   frame_err
);

    localparam logic [PROG_ADDR_W-1:0] LAST_ADDR = PROG_ADDR_W'(PROG_DEPTH - 1);

    ldr_state_t             r_state;
    logic [PROG_ADDR_W-1:0] r_byte_cnt;
    logic                   r_prog;
    logic [PROG_ADDR_W-1:0] r_addr;
    logic [PROG_DATA_W-1:0] r_data;
    logic                   r_cpu_reset;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_frame_err;

    logic                   w_rx_en;
    logic                   w_byte_valid;
    logic [PROG_DATA_W-1:0] w_byte_data;
    logic                   w_stop_err;

    // Receiver runs only while waiting for or committing a byte
    assign w_rx_en = (r_state == LDR_ARM) || (r_state == LDR_WRITE);

    prog_loader_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .i_en         (w_rx_en),
        .i_rx         (rx),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_stop_err   (w_stop_err)
    );

    // Session control and CPU-facing registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= LDR_IDLE;
            r_byte_cnt  <= '0;
            r_prog      <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_prog <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                LDR_IDLE: begin
                    r_cpu_reset <= 1'b0;
                    r_busy      <= 1'b0;
                    if (load_start) begin
                        r_state     <= LDR_ARM;
                        r_byte_cnt  <= '0;
                        r_frame_err <= 1'b0;
                        r_cpu_reset <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                LDR_ARM: begin
                    if (w_byte_valid) begin
                        // prog is high exactly during WRITE; addr/data hold afterwards
                        r_state <= LDR_WRITE;
                        r_prog  <= 1'b1;
                        r_addr  <= r_byte_cnt;
                        r_data  <= w_byte_data;
                    end else if (w_stop_err) begin
                        r_frame_err <= 1'b1;
                    end
                end
                LDR_WRITE: begin
                    if (r_byte_cnt == LAST_ADDR) begin
                        r_state <= LDR_RELEASE;
                        r_done  <= 1'b1;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + PROG_ADDR_W'(1);
                        r_state    <= LDR_ARM;
                    end
                end
                LDR_RELEASE: begin
                    r_cpu_reset <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= LDR_IDLE;
                end
                default: begin
                    r_state <= LDR_IDLE;
                end
            endcase
        end
    end

    assign prog           = r_prog;
    assign addr           = r_addr;
    assign programm_input = r_data;
    assign cpu_reset      = r_cpu_reset;
    assign busy           = r_busy;
    assign done           = r_done;
    assign frame_err      = r_frame_err;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a session-level reference model.
module tb_prog_loader;

    localparam int unsigned CPB = 16;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       rx         = 1'b1;
    logic       load_start = 1'b0;
    logic       prog;
    logic [3:0] addr;
    logic [7:0] programm_input;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;

    // monitor bookkeeping
    int   cyc         = 0;
    int   n_done      = 0;
    int   t_done      = -1;
    int   t_busy_fall = -1;
    int   t_cr_fall   = -1;
    logic prev_busy   = 1'b0;
    logic prev_cr     = 1'b1;
    logic [11:0] obs_q[$];

    // reference model: expected {addr,data} writes of the current session
    logic [11:0] exp_q[$];
    bit m_active = 1'b0;
    int m_addr   = 0;
    bit m_ferr   = 1'b0;

    always #5 clk = ~clk;

    prog_loader #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .load_start     (load_start),
        .prog           (prog),
        .addr           (addr),
        .programm_input (programm_input),
        .cpu_reset      (cpu_reset),
        .busy           (busy),
        .done           (done),
        .frame_err      (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record RAM writes and session edges on the falling clock edge
    always @(negedge clk) begin
        cyc++;
        if (prog) begin
            obs_q.push_back({addr, programm_input});
            check("cpu_reset_at_prog", 32'(cpu_reset), 32'd1);
        end
        if (done) begin
            n_done++;
            t_done = cyc;
        end
        if (!reset) begin
            if (prev_busy && !busy)     t_busy_fall = cyc;
            if (prev_cr && !cpu_reset)  t_cr_fall   = cyc;
        end
        prev_busy = busy;
        prev_cr   = cpu_reset;
    end

    function automatic void model_frame(input logic [7:0] d, input bit ok);
        if (m_active) begin
            if (ok) begin
                exp_q.push_back({4'(m_addr), d});
                m_addr++;
                if (m_addr == 16) m_active = 1'b0;
            end else begin
                m_ferr = 1'b1;
            end
        end
    endfunction

    // Drive one 8N1 frame starting at a falling clock edge
    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        model_frame(d, stop_ok);
    endtask

    task automatic start_session();
        bit was_active;
        was_active = m_active;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        if (!was_active) begin
            m_active = 1'b1;
            m_addr   = 0;
            m_ferr   = 1'b0;
        end
        check("busy_after_start", 32'(busy), 32'd1);
        check("cpu_reset_after_start", 32'(cpu_reset), 32'd1);
    endtask

    task automatic verify_writes(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          base_done;
        logic [11:0] w3;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_prog", 32'(prog), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(programm_input), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("cpu_reset_released", 32'(cpu_reset), 32'd0);

        // frames in IDLE are ignored
        repeat (4) @(negedge clk);
        send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b1);
        repeat (8) @(negedge clk);
        verify_writes("idle_frames");
        check("idle_busy", 32'(busy), 32'd0);

        // full load with 0x60+i, stray load_start mid-session
        base_done = n_done;
        start_session();
        t_done = -1; t_busy_fall = -1; t_cr_fall = -1;
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(8'h60 + i), 1'b1);
            if (i == 5) start_session();
            repeat ($urandom_range(0, CPB)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        verify_writes("full_load");
        check("full_done_count", 32'(n_done - base_done), 32'd1);
        check("cr_falls_with_busy", 32'(t_cr_fall), 32'(t_busy_fall));
        check("busy_falls_after_done", 32'(t_busy_fall), 32'(t_done + 1));
        check("full_cpu_reset_low", 32'(cpu_reset), 32'd0);

        // frame error on the 4th frame, then 0xA5 goes to address 3
        base_done = n_done;
        start_session();
        for (int i = 0; i < 3; i++) begin
            send_frame(8'($urandom), 1'b1);
            repeat ($urandom_range(0, CPB)) @(negedge clk);
        end
        send_frame(8'($urandom), 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("frame_err_set", 32'(frame_err), 32'(m_ferr));
        check("ferr_no_prog", 32'(obs_q.size()), 32'd3);
        send_frame(8'hA5, 1'b1);
        for (int i = 0; i < 12; i++) begin
            send_frame(8'($urandom), 1'b1);
            repeat ($urandom_range(0, CPB)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        w3 = (obs_q.size() > 3) ? obs_q[3] : 12'hFFF;
        check("a5_at_addr3", 32'(w3), 32'h3A5);
        verify_writes("ferr_load");
        check("ferr_done_count", 32'(n_done - base_done), 32'd1);
        check("frame_err_sticky", 32'(frame_err), 32'(m_ferr));

        // glitch in ARM, then 0x3C at address 0 and four more bytes
        start_session();
        check("ferr_cleared", 32'(frame_err), 32'(m_ferr));
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_no_prog", 32'(obs_q.size()), 32'd0);
        check("glitch_busy", 32'(busy), 32'd1);
        send_frame(8'h3C, 1'b1);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, CPB)) @(negedge clk);
            send_frame(8'($urandom), 1'b1);
        end
        repeat (4) @(negedge clk);
        verify_writes("glitch_load");

        // reset in the middle of a session
        #2 reset = 1'b1;
        #1;
        check("midrst_prog", 32'(prog), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_addr", 32'(addr), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        m_active = 1'b0;
        m_addr   = 0;
        m_ferr   = 1'b0;
        #1 check("midrst_cr_held", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        check("midrst_cr_fall", 32'(cpu_reset), 32'd0);

        // back-to-back random frames with no idle time
        base_done = n_done;
        start_session();
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1);
        repeat (8) @(negedge clk);
        verify_writes("b2b_load");
        check("b2b_done_count", 32'(n_done - base_done), 32'd1);
        check("b2b_busy_low", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
